// File: rtl/pulse_catcher.sv
// pulse_catcher: synchronizes a held level into Clk and regenerates one single-cycle pulse per event,
// queuing undelivered events in a saturating counter and flagging overflow and a stuck-high input.
module pulse_catcher #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PEND    = 7,
    parameter int STUCK_LIM   = 64,
    localparam int PW         = $clog2(MAX_PEND + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_in,
    input  logic          i_ready,
    input  logic          i_ovf_clr,
    output logic          o_pulse,
    output logic [PW-1:0] o_pending,
    output logic          o_ovf,
    output logic          o_stuck
);
    localparam int HW = $clog2(STUCK_LIM);
    localparam logic [HW-1:0] HLIM = HW'(STUCK_LIM - 2);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
    typedef enum logic [1:0] {S_ARM, S_IDLE, S_HIGH, S_STUCK} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync, r_vld;
    logic [HW-1:0]          r_hcnt;
    logic [PW-1:0]          r_pend;
    logic                   w_sy, w_rise, w_take, w_drop;
    assign w_sy      = r_sync[SYNC_STAGES-1];
    assign o_pending = r_pend;
    // r_vld marks when w_sy carries a real post-reset sample, so the reset zeros never pass for a low
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= S_ARM;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARM:   w_next = (r_vld[SYNC_STAGES-1] && !w_sy) ? S_IDLE : S_ARM;
            S_IDLE:  w_next = w_sy ? S_HIGH : S_IDLE;
            S_HIGH:  w_next = !w_sy ? S_IDLE : (r_hcnt == HLIM) ? S_STUCK : S_HIGH;
            default: w_next = w_sy ? S_STUCK : S_IDLE;
        endcase
    end
    always_comb begin
        w_rise = (r_state == S_IDLE) && w_sy;
        w_take = i_ready && (r_pend != '0 || w_rise);
        w_drop = w_rise && !w_take && r_pend == PMAX;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hcnt  <= '0;
            o_stuck <= 1'b0;
        end else begin
            r_hcnt  <= (r_state == S_IDLE) ? '0 :
                       (r_state == S_HIGH && w_sy) ? r_hcnt + HW'(1) : r_hcnt;
            o_stuck <= (w_next == S_STUCK);
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            o_pulse <= 1'b0;
            r_pend  <= '0;
            o_ovf   <= 1'b0;
        end else begin
            o_pulse <= w_take;
            r_pend  <= w_drop ? r_pend : r_pend + PW'(w_rise) - PW'(w_take);
            o_ovf   <= w_drop | (o_ovf & ~i_ovf_clr);
        end
    end
endmodule
